// File: rtl/fpga_status_pkg.sv
// Shared types for the board status controller: LED modes, exit status and code FSM states.
package fpga_status_pkg;

  localparam int unsigned LedModeWidth = 3;
  localparam int unsigned GapTicks     = 3;
  localparam int unsigned GapCntWidth  = 2;

  typedef enum logic [2:0] {
    LedOff    = 3'd0,
    LedOn     = 3'd1,
    LedHb     = 3'd2,
    LedRst    = 3'd3,
    LedStatus = 3'd4,
    LedTick   = 3'd5,
    LedRsvd6  = 3'd6,
    LedRsvd7  = 3'd7
  } led_mode_e;

  typedef enum logic [1:0] {
    StatusRun  = 2'b00,
    StatusPass = 2'b01,
    StatusFail = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    StIdle,
    StPulseOn,
    StPulseOff,
    StGap
  } code_state_e;

  // LED value shown in STATUS mode: solid on pass, blinking exit code on fail.
  function automatic logic status_led(input status_e status, input logic code_led);
    logic led;
    led = 1'b0;
    unique case (status)
      StatusRun:  led = 1'b0;
      StatusPass: led = 1'b1;
      StatusFail: led = code_led;
      default:    led = 1'b0;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/fpga_tick_gen.sv
// Slow strobe generator: one-cycle tick_o every TICK_DIV clk_gen cycles.
module fpga_tick_gen
  import fpga_status_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2_000_000
) (
  input  logic clk_gen,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned CntWidth = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TICK_DIV - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fpga_board_status_ctrl.sv
// Board-visibility controller: reset sync, heartbeat, exit-status capture,
// exit-code blink train and per-LED mode mux.
module fpga_board_status_ctrl
  import fpga_status_pkg::*;
#(
  parameter int unsigned HB_CNT_WIDTH = 27,
  parameter int unsigned TICK_DIV     = 2_000_000,
  parameter int unsigned NUM_LEDS     = 4,
  parameter int unsigned CODE_WIDTH   = 4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                                clk_gen,
  input  logic                                rst_n,
  output logic                                rst_sync_no,
  input  logic                                exit_valid_i,
  input  logic [31:0]                         exit_value_i,
  input  logic [NUM_LEDS*LedModeWidth-1:0]    led_mode_i,
  output logic [NUM_LEDS-1:0]                 led_o,
  output logic                                hb_o,
  output logic [1:0]                          status_o
);

  localparam int unsigned PulseWidth = CODE_WIDTH + 1;
  localparam logic [GapCntWidth-1:0] GapLast = GapCntWidth'(GapTicks - 1);

  // Reset synchroniser: asserts with rst_n, releases after SYNC_STAGES edges.
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_no = sync_q[SYNC_STAGES-1];

  // Heartbeat
  logic [HB_CNT_WIDTH-1:0] hb_cnt_q;

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_q <= '0;
    end else begin
      hb_cnt_q <= hb_cnt_q + 1'b1;
    end
  end

  assign hb_o = hb_cnt_q[HB_CNT_WIDTH-1];

  // Blink tick and its toggle
  logic tick;
  logic tick_tgl_q;

  fpga_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk_gen(clk_gen),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      tick_tgl_q <= 1'b0;
    end else if (tick) begin
      tick_tgl_q <= ~tick_tgl_q;
    end
  end

  // Exit capture: only the first exit after the synchronised reset releases counts.
  status_e               status_q, status_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;

  always_comb begin
    status_d = status_q;
    code_d   = code_q;
    if (rst_sync_no && exit_valid_i && (status_q == StatusRun)) begin
      status_d = (exit_value_i == '0) ? StatusPass : StatusFail;
      code_d   = exit_value_i[CODE_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= StatusRun;
      code_q   <= '0;
    end else begin
      status_q <= status_d;
      code_q   <= code_d;
    end
  end

  assign status_o = status_q;

  // Code FSM: a zero code blinks the full 2**CODE_WIDTH pulses.
  code_state_e            state_q, state_d;
  logic [PulseWidth-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic [GapCntWidth-1:0] gap_cnt_q, gap_cnt_d;
  logic [PulseWidth-1:0]  pulse_num;
  logic                   code_led;

  assign pulse_num = (code_q == '0) ? {1'b1, {CODE_WIDTH{1'b0}}} : {1'b0, code_q};

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pulse_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (status_q == StatusFail) begin
            state_d = StPulseOn;
          end
        end
        StPulseOn: begin
          state_d     = StPulseOff;
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
        StPulseOff: begin
          state_d = (pulse_cnt_q < pulse_num) ? StPulseOn : StGap;
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_d     = StPulseOn;
            gap_cnt_d   = '0;
            pulse_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    code_led = (state_q == StPulseOn);
  end

  // LED mode mux, registered
  logic [NUM_LEDS-1:0] led_q, led_d;

  always_comb begin
    led_d = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      case (led_mode_e'(led_mode_i[LedModeWidth*k +: LedModeWidth]))
        LedOff:    led_d[k] = 1'b0;
        LedOn:     led_d[k] = 1'b1;
        LedHb:     led_d[k] = hb_o;
        LedRst:    led_d[k] = ~rst_sync_no;
        LedStatus: led_d[k] = status_led(status_q, code_led);
        LedTick:   led_d[k] = tick_tgl_q;
        default:   led_d[k] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: tb/tb_fpga_board_status_ctrl.sv
// Self-checking bench for fpga_board_status_ctrl with small counters and a fast blink tick.
module tb_fpga_board_status_ctrl;

  logic        clk_gen = 1'b0;
  logic        rst_n;
  logic        rst_sync_no;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic [11:0] led_mode_i;
  logic [3:0]  led_o;
  logic        hb_o;
  logic [1:0]  status_o;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle values; low bit is the LED1 value for train checks.
  logic [4:0] exp_q[$];

  always #5 clk_gen = ~clk_gen;

  fpga_board_status_ctrl #(
    .HB_CNT_WIDTH(4),
    .TICK_DIV    (4),
    .NUM_LEDS    (4),
    .CODE_WIDTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk_gen     (clk_gen),
    .rst_n       (rst_n),
    .rst_sync_no (rst_sync_no),
    .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i),
    .led_mode_i  (led_mode_i),
    .led_o       (led_o),
    .hb_o        (hb_o),
    .status_o    (status_o)
  );

  task automatic step();
    @(posedge clk_gen);
    @(negedge clk_gen);
  endtask

  // Leaves rst_n released at a falling edge; the next rising edge is edge 1.
  task automatic apply_reset(input logic [11:0] modes);
    rst_n        = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = '0;
    led_mode_i   = modes;
    repeat (2) @(negedge clk_gen);
    rst_n = 1'b1;
  endtask

  task automatic send_exit(input logic [31:0] value);
    exit_valid_i = 1'b1;
    exit_value_i = value;
    step();
    exit_valid_i = 1'b0;
  endtask

  // Train of n pulses (4 high / 4 low), last low stretched to 16, then next train's first pulse.
  function automatic void push_train(input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(5'd1);
      for (int i = 0; i < ((p == n - 1) ? 16 : 4); i++) exp_q.push_back(5'd0);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(5'd1);
  endfunction

  task automatic wait_rise(output bit seen);
    int n;
    n = 0;
    while (led_o[1] !== 1'b1 && n < 80) begin
      step();
      n++;
    end
    seen = (led_o[1] === 1'b1);
  endtask

  task automatic test_reset();
    logic [4:0] e;
    exp_q.delete();
    rst_n        = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = '0;
    led_mode_i   = {4{3'd1}};
    repeat (3) @(negedge clk_gen);
    checks++;
    if (led_o !== 4'b0 || hb_o !== 1'b0 || status_o !== 2'b00 || rst_sync_no !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: led=%b hb=%b status=%b sync=%b, required all zero",
               led_o, hb_o, status_o, rst_sync_no);
    end
    led_mode_i = '0;
    rst_n      = 1'b1;
    for (int k = 1; k <= 4; k++) exp_q.push_back((k >= 2) ? 5'd1 : 5'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (rst_sync_no !== e[0]) begin
        errors++;
        $display("FAIL rst_sync edge %0d: got %b, required %b", k, rst_sync_no, e[0]);
      end
      if (k < 2) begin
        checks++;
        if (led_o !== 4'b0 || hb_o !== 1'b0 || status_o !== 2'b00) begin
          errors++;
          $display("FAIL release_quiet edge %0d: led=%b hb=%b status=%b, required zero",
                   k, led_o, hb_o, status_o);
        end
      end
    end
  endtask

  task automatic test_heartbeat();
    logic       hb_e, l0, l2, l3;
    logic [4:0] e;
    exp_q.delete();
    // LED3=~rst_sync, LED2=tick_tgl, LED1=status, LED0=heartbeat
    apply_reset(12'h762);
    for (int k = 1; k <= 40; k++) begin
      hb_e = ((k % 16) >= 8);
      l0   = (((k - 1) % 16) >= 8);
      l2   = ((((k - 1) / 4) % 2) == 1);
      l3   = (k <= 2);
      exp_q.push_back({hb_e, l3, l2, 1'b0, l0});
    end
    for (int k = 1; k <= 40; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({hb_o, led_o} !== e) begin
        errors++;
        $display("FAIL heartbeat edge %0d: {hb,led}=%b, required %b", k, {hb_o, led_o}, e);
      end
    end
  endtask

  task automatic test_pass();
    logic [4:0] e;
    exp_q.delete();
    apply_reset(12'h020);
    // Exit during the reset-release window must be ignored.
    exit_valid_i = 1'b1;
    exit_value_i = 32'h3;
    step();
    step();
    exit_valid_i = 1'b0;
    step();
    checks++;
    if (status_o !== 2'b00) begin
      errors++;
      $display("FAIL early_exit_ignored: status=%b, required 00", status_o);
    end
    send_exit(32'h0);
    checks++;
    if (status_o !== 2'b01) begin
      errors++;
      $display("FAIL pass_status: status=%b, required 01", status_o);
    end
    send_exit(32'h5);
    checks++;
    if (status_o !== 2'b01) begin
      errors++;
      $display("FAIL pass_sticky: status=%b, required 01", status_o);
    end
    for (int i = 0; i < 20; i++) exp_q.push_back(5'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led_o[1] !== e[0]) begin
        errors++;
        $display("FAIL pass_led: led1=%b, required %b", led_o[1], e[0]);
      end
      step();
    end
  endtask

  task automatic test_fail_code3();
    logic [4:0] e;
    bit         seen;
    int         i;
    exp_q.delete();
    apply_reset(12'h020);
    repeat (3) step();
    send_exit(32'h3);
    checks++;
    if (status_o !== 2'b10) begin
      errors++;
      $display("FAIL fail_status: status=%b, required 10", status_o);
    end
    push_train(3);
    wait_rise(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL code3_start: led1=%b, required 1 within 80 cycles", led_o[1]);
      exp_q.delete();
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led_o[1] !== e[0]) begin
        errors++;
        $display("FAIL code3_train cycle %0d: led1=%b, required %b", i, led_o[1], e[0]);
      end
      // Mode changes on other LEDs must not disturb the train.
      if (i == 10) led_mode_i = 12'h161;
      step();
      i++;
    end
  endtask

  task automatic test_fail_code16();
    logic [4:0] e;
    bit         seen;
    int         i;
    exp_q.delete();
    apply_reset(12'h020);
    repeat (3) step();
    send_exit(32'h10);
    checks++;
    if (status_o !== 2'b10) begin
      errors++;
      $display("FAIL code16_status: status=%b, required 10", status_o);
    end
    push_train(16);
    wait_rise(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL code16_start: led1=%b, required 1 within 80 cycles", led_o[1]);
      exp_q.delete();
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led_o[1] !== e[0]) begin
        errors++;
        $display("FAIL code16_train cycle %0d: led1=%b, required %b", i, led_o[1], e[0]);
      end
      if (i == 20) begin
        exit_valid_i = 1'b1;
        exit_value_i = 32'h0;
      end else begin
        exit_valid_i = 1'b0;
      end
      step();
      i++;
    end
    checks++;
    if (status_o !== 2'b10) begin
      errors++;
      $display("FAIL code16_second_exit: status=%b, required 10", status_o);
    end
  endtask

  task automatic test_reset_mid_train();
    logic [4:0] e;
    bit         seen;
    exp_q.delete();
    apply_reset(12'h020);
    repeat (3) step();
    send_exit(32'h3);
    wait_rise(seen);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || led_o !== 4'b0 || status_o !== 2'b00 || rst_sync_no !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: seen=%0d led=%b status=%b sync=%b, required seen=1 rest zero",
               seen, led_o, status_o, rst_sync_no);
    end
    @(negedge clk_gen);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) exp_q.push_back(5'd0);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (led_o[1] !== e[0] || status_o !== 2'b00) begin
        errors++;
        $display("FAIL post_reset_idle: led1=%b status=%b, required %b and 00",
                 led_o[1], status_o, e[0]);
      end
    end
    send_exit(32'h1);
    push_train(1);
    wait_rise(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL restart_start: led1=%b, required 1 within 80 cycles", led_o[1]);
      exp_q.delete();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led_o[1] !== e[0]) begin
        errors++;
        $display("FAIL restart_train: led1=%b, required %b", led_o[1], e[0]);
      end
      step();
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = '0;
    led_mode_i   = '0;
    test_reset();
    test_heartbeat();
    test_pass();
    test_fail_code3();
    test_fail_code16();
    test_reset_mid_train();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
